// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: request-op field positions, size codes and FSM state encoding.
package mem_access_unit_pkg;
  localparam int OP_ST = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store strobes and lane replication, load alignment and extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OW-1:0]     off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     wstrb,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);
  logic [7:0] base;
  logic [OW-1:0] lane_mask;
  logic [DATA_W-1:0] sh, mask;
  logic sgn;
  always_comb begin
    base = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    wstrb = NB'(base) << off;
    lane_mask = OW'((4'd1 << size) - 4'd1);
    sh = rdata >> {off, 3'b000};
    mask = size == SZ_B ? DATA_W'(8'hFF) : size == SZ_H ? DATA_W'(16'hFFFF) :
           size == SZ_W ? DATA_W'(32'hFFFF_FFFF) : '1;
    sgn = ~uns & (size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : size == SZ_W ? sh[31] : sh[DATA_W-1]);
    rdata_ext = (sh & mask) | ({DATA_W{sgn}} & ~mask);
  end
  // each lane takes the store byte at its position modulo the access size
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign wdata_rep[8*i +: 8] = wdata[{OW'(i) & lane_mask, 3'b000} +: 8];
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a split-phase sram-like data bus.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_adel,
  output logic              resp_ades,
  output logic [ADDR_W-1:0] resp_badvaddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [NB-1:0]     data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok
);
  logic [1:0] state;
  logic cancel, adel, ades, legal;
  logic [3:0] op, lo_mask;
  logic [ADDR_W-1:0] addr, bad;
  logic [DATA_W-1:0] wdata, rdata_q, wrep, ld;
  logic [NB-1:0] strb;
  always_comb begin
    lo_mask = 4'((5'd1 << req_op[1:0]) - 5'd1);
    legal = (({1'b0, req_addr[2:0]} & lo_mask) == 4'd0) && ({30'd0, req_op[1:0]} <= 32'(OW));
  end
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size(op[1:0]),
    .uns(op[OP_UNS]),
    .off(addr[OW-1:0]),
    .wdata(wdata),
    .rdata(data_rdata),
    .wstrb(strb),
    .wdata_rep(wrep),
    .rdata_ext(ld)
  );
  assign req_ready = (state == S_IDLE) & ~rst;
  assign data_req = state == S_REQ;
  assign data_wr = data_req & op[OP_ST];
  assign data_size = data_req ? op[1:0] : 2'd0;
  assign data_addr = data_req ? addr : '0;
  assign data_wstrb = data_wr ? strb : '0;
  assign data_wdata = data_wr ? wrep : '0;
  assign resp_valid = (state == S_RESP) & ~cancel & ~flush;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_adel = resp_valid & adel;
  assign resp_ades = resp_valid & ades;
  assign resp_badvaddr = resp_valid ? bad : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cancel <= 1'b0;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      rdata_q <= '0;
      adel <= 1'b0;
      ades <= 1'b0;
      bad <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        op <= req_op;
        addr <= req_addr;
        wdata <= req_wdata;
        rdata_q <= '0;
        adel <= ~legal & ~req_op[OP_ST];
        ades <= ~legal & req_op[OP_ST];
        bad <= legal ? '0 : req_addr;
        state <= legal ? S_REQ : S_RESP;
      end
      // once addr_ok is seen the transfer is issued and must drain even if flushed
      if (state == S_REQ) begin
        if (data_addr_ok) begin
          cancel <= flush;
          state <= data_data_ok ? S_RESP : S_WAIT;
        end else if (flush) state <= S_IDLE;
      end
      if (state == S_WAIT) begin
        cancel <= cancel | flush;
        if (data_data_ok) state <= S_RESP;
      end
      if (((state == S_REQ && data_addr_ok) || state == S_WAIT) && data_data_ok)
        rdata_q <= op[OP_ST] ? '0 : ld;
      if (state == S_RESP) begin
        state <= S_IDLE;
        cancel <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of both bus widths against a reference model.
module tb_mem_access_unit;
  logic clk = 1'b0, rst, req_valid, flush, data_addr_ok, data_data_ok, sel;
  logic [3:0] req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, data_rdata;
  int checks = 0, failures = 0;
  logic r32_ready, r32_rv, r32_adel, r32_ades, r32_dreq, r32_dwr;
  logic [31:0] r32_rdata, r32_bad, r32_daddr, r32_wdata;
  logic [1:0] r32_dsize;
  logic [3:0] r32_wstrb;
  logic r64_ready, r64_rv, r64_adel, r64_ades, r64_dreq, r64_dwr;
  logic [63:0] r64_rdata, r64_wdata;
  logic [31:0] r64_bad, r64_daddr;
  logic [1:0] r64_dsize;
  logic [7:0] r64_wstrb;
  logic o_ready, o_rv, o_adel, o_ades, o_dreq, o_dwr;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_bad, o_daddr;
  logic [1:0] o_dsize;
  logic [7:0] o_wstrb;
  always #5 clk = ~clk;
  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(r32_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .flush(flush), .resp_valid(r32_rv),
    .resp_rdata(r32_rdata), .resp_adel(r32_adel), .resp_ades(r32_ades), .resp_badvaddr(r32_bad),
    .data_req(r32_dreq), .data_wr(r32_dwr), .data_size(r32_dsize), .data_addr(r32_daddr),
    .data_wstrb(r32_wstrb), .data_wdata(r32_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata[31:0]), .data_data_ok(data_data_ok)
  );
  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(r64_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush), .resp_valid(r64_rv),
    .resp_rdata(r64_rdata), .resp_adel(r64_adel), .resp_ades(r64_ades), .resp_badvaddr(r64_bad),
    .data_req(r64_dreq), .data_wr(r64_dwr), .data_size(r64_dsize), .data_addr(r64_daddr),
    .data_wstrb(r64_wstrb), .data_wdata(r64_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );
  assign o_ready = sel ? r64_ready : r32_ready;
  assign o_rv = sel ? r64_rv : r32_rv;
  assign o_adel = sel ? r64_adel : r32_adel;
  assign o_ades = sel ? r64_ades : r32_ades;
  assign o_dreq = sel ? r64_dreq : r32_dreq;
  assign o_dwr = sel ? r64_dwr : r32_dwr;
  assign o_rdata = sel ? r64_rdata : {32'd0, r32_rdata};
  assign o_wdata = sel ? r64_wdata : {32'd0, r32_wdata};
  assign o_bad = sel ? r64_bad : r32_bad;
  assign o_daddr = sel ? r64_daddr : r32_daddr;
  assign o_dsize = sel ? r64_dsize : r32_dsize;
  assign o_wstrb = sel ? r64_wstrb : {4'd0, r32_wstrb};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s w64=%0b got=%h exp=%h", tag, sel, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_legal(input bit w, input logic [1:0] sz, input logic [31:0] a);
    return (int'(sz) <= (w ? 3 : 2)) && (a % (32'd1 << sz) == 0);
  endfunction

  function automatic logic [63:0] m_strb(input bit w, input logic [1:0] sz, input logic [31:0] a);
    int nb = w ? 8 : 4;
    int off = int'(a % nb);
    logic [63:0] s = '0;
    for (int i = 0; i < nb; i++) if (i >= off && i < off + (1 << sz)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input bit w, input logic [1:0] sz, input logic [63:0] wd);
    int nb = w ? 8 : 4;
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = wd[8*(i % (1 << sz)) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] m_load(input bit w, input logic [3:0] op, input logic [31:0] a,
                                         input logic [63:0] rd);
    int nb = w ? 8 : 4;
    int bits = 8 << op[1:0];
    logic [63:0] v = (w ? rd : {32'd0, rd[31:0]}) >> (8 * (a % nb));
    if (bits < 64) begin
      v = v & ((64'd1 << bits) - 64'd1);
      if (!op[2] && v[bits-1]) v = v | ~((64'd1 << bits) - 64'd1);
    end
    return w ? v : {32'd0, v[31:0]};
  endfunction

  // fm: 0 none, 1 flush in REQ at cycle fat, 2 flush in WAIT cycle fat, 3 flush in RESP, 4 flush with addr_ok
  task automatic txn(input bit w, input logic [3:0] op, input logic [31:0] a, input logic [63:0] wd,
                     input logic [63:0] rd, input int alat, input int dlat, input int fm, input int fat);
    bit st = op[3];
    logic [1:0] sz = op[1:0];
    bit lg = m_legal(w, sz, a);
    bit sup = (fm == 2 || fm == 3 || fm == 4);
    sel = w;
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    #1 chk("accept_ready", o_ready, 1);
    tick;
    req_valid = 1'b0;
    req_op = 4'($urandom);
    req_addr = $urandom;
    req_wdata = {$urandom, $urandom};
    #1;
    if (!lg) begin
      chk("err_rv", o_rv, 1);
      chk("err_adel", o_adel, !st);
      chk("err_ades", o_ades, st);
      chk("err_bad", o_bad, a);
      chk("err_dreq", o_dreq, 0);
      chk("err_rdata", o_rdata, 0);
      tick;
      #1;
      chk("err_rv_after", o_rv, 0);
      chk("err_ready_after", o_ready, 1);
      chk("err_dreq_after", o_dreq, 0);
      return;
    end
    for (int k = 0; k <= alat; k++) begin
      chk("req_dreq", o_dreq, 1);
      chk("req_addr", o_daddr, a);
      chk("req_wr", o_dwr, st);
      chk("req_size", o_dsize, sz);
      chk("req_wstrb", o_wstrb, st ? m_strb(w, sz, a) : 64'd0);
      if (st) chk("req_wdata", o_wdata, m_wdata(w, sz, wd));
      chk("req_rv", o_rv, 0);
      if (fm == 1 && k == fat) begin
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1;
        chk("flreq_dreq", o_dreq, 0);
        chk("flreq_ready", o_ready, 1);
        chk("flreq_rv", o_rv, 0);
        return;
      end
      if (k == alat) begin
        data_addr_ok = 1'b1;
        data_data_ok = (dlat == 0);
        data_rdata = rd;
        flush = (fm == 4);
      end
      tick;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      flush = 1'b0;
      data_rdata = {$urandom, $urandom};
      #1;
    end
    for (int j = 1; j <= dlat; j++) begin
      chk("wait_dreq", o_dreq, 0);
      chk("wait_rv", o_rv, 0);
      if (fm == 2 && j == fat) flush = 1'b1;
      if (j == dlat) begin
        data_data_ok = 1'b1;
        data_rdata = rd;
      end
      tick;
      flush = 1'b0;
      data_data_ok = 1'b0;
      data_rdata = {$urandom, $urandom};
      #1;
    end
    if (fm == 3) begin
      flush = 1'b1;
      #1;
    end
    chk("resp_rv", o_rv, !sup);
    chk("resp_rdata", o_rdata, (sup || st) ? 64'd0 : m_load(w, op, a, rd));
    chk("resp_adel", o_adel, 0);
    chk("resp_ades", o_ades, 0);
    chk("resp_bad", o_bad, 0);
    chk("resp_ready", o_ready, 0);
    tick;
    flush = 1'b0;
    #1;
    chk("idle_rv", o_rv, 0);
    chk("idle_ready", o_ready, 1);
    chk("idle_rdata", o_rdata, 0);
  endtask

  // reset while a 64-bit transfer is in REQ (store) or WAIT (load)
  task automatic rst_mid(input bit in_req);
    sel = 1'b1;
    req_op = in_req ? 4'b1011 : 4'b0011;
    req_addr = 32'h4008;
    req_wdata = 64'h0123_4567_89AB_CDEF;
    req_valid = 1'b1;
    #1;
    tick;
    req_valid = 1'b0;
    #1;
    chk("rst_pre_dreq", o_dreq, 1);
    if (!in_req) begin
      data_addr_ok = 1'b1;
      tick;
      data_addr_ok = 1'b0;
      #1;
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_dreq", o_dreq, 0);
    chk("rst_daddr", o_daddr, 0);
    chk("rst_wstrb", o_wstrb, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_dwr", o_dwr, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_rv", o_rv, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", o_ready, 1);
    chk("rst_release_dreq", o_dreq, 0);
  endtask

  initial begin
    bit w;
    logic [3:0] op;
    logic [31:0] a;
    int alat, dlat, fm, fat;
    rst = 1'b1;
    sel = 1'b0;
    req_valid = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_wdata = '0;
    flush = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_rv", o_rv, 0);
      chk("reset_dreq", o_dreq, 0);
      chk("reset_wstrb", o_wstrb, 0);
      chk("reset_daddr", o_daddr, 0);
      chk("reset_rdata", o_rdata, 0);
      chk("reset_ready", o_ready, 0);
    end
    rst = 1'b0;
    #1 chk("reset_release_ready", o_ready, 1);
    tick;
    txn(0, 4'b1000, 32'h1003, 64'hA5, 64'h0, 0, 1, 0, 0);
    txn(0, 4'b1000, 32'h1003, 64'hA5, 64'h0, 0, 0, 0, 0);
    txn(0, 4'b0001, 32'h2002, 64'h0, 64'h8001_1234, 0, 1, 0, 0);
    txn(0, 4'b0101, 32'h2002, 64'h0, 64'h8001_1234, 0, 1, 0, 0);
    txn(0, 4'b1010, 32'h3002, 64'h55, 64'h0, 0, 1, 0, 0);
    txn(0, 4'b0010, 32'h3001, 64'h0, 64'h0, 0, 1, 0, 0);
    txn(0, 4'b0011, 32'h3000, 64'h0, 64'h0, 0, 1, 0, 0);
    txn(0, 4'b1010, 32'h3004, 64'hDEAD_BEEF, 64'h0, 3, 1, 0, 0);
    txn(0, 4'b0000, 32'h3005, 64'h0, 64'h1234_80FF, 0, 0, 0, 0);
    txn(0, 4'b1001, 32'h3006, 64'hBEEF, 64'h0, 2, 1, 1, 0);
    txn(0, 4'b0010, 32'h3008, 64'h0, 64'h1111_2222, 0, 4, 2, 1);
    txn(0, 4'b0010, 32'h300C, 64'h0, 64'h3333_4444, 0, 1, 3, 0);
    txn(0, 4'b0010, 32'h3010, 64'h0, 64'h5555_6666, 1, 2, 4, 0);
    txn(1, 4'b1010, 32'h4004, 64'h1122_3344, 64'h0, 0, 1, 0, 0);
    txn(1, 4'b0011, 32'h4008, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 0, 1, 0, 0);
    txn(1, 4'b0110, 32'h400C, 64'h0, 64'h8765_4321_0000_0000, 1, 1, 0, 0);
    txn(1, 4'b1011, 32'h4004, 64'h0, 64'h0, 0, 1, 0, 0);
    rst_mid(0);
    rst_mid(1);
    repeat (150) begin
      w = 1'($urandom);
      op = 4'($urandom);
      a = $urandom;
      if ($urandom % 4 != 0) a = a & ~((32'd1 << op[1:0]) - 32'd1);
      alat = $urandom % 4;
      dlat = $urandom % 4;
      fm = $urandom % 6;
      if (fm == 5) fm = 0;
      fat = 0;
      if (fm == 1) begin
        if (alat == 0) fm = 0;
        else fat = $urandom % alat;
      end
      if (fm == 2) begin
        if (dlat == 0) fm = 0;
        else fat = 1 + $urandom % dlat;
      end
      txn(w, op, a, {$urandom, $urandom}, {$urandom, $urandom}, alat, dlat, fm, fat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
